// File: rtl/ucdp_afifo_wr.sv
// ucdp_afifo_wr: source-domain write adapter with 2-entry skid buffer and packet space reservation
module ucdp_afifo_wr #(
  parameter int unsigned dwidth_p  = 8,
  parameter int unsigned awidth_p  = 4,
  parameter bit          pktmode_p = 1'b1,
  parameter int unsigned maxpkt_p  = 4
) (
  input  logic                src_clk_i,
  input  logic                src_rst_an_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [dwidth_p-1:0] s_data_i,
  input  logic                s_last_i,
  output logic                fifo_wr_en_o,
  output logic [dwidth_p-1:0] fifo_wr_data_o,
  input  logic                fifo_wr_full_i,
  input  logic [awidth_p-1:0] fifo_wr_space_avail_i,
  output logic                busy_o,
  output logic                err_pktlen_o
);
  typedef enum logic [1:0] {IDLE, BURST, OVER} state_t;
  state_t              state;
  logic [dwidth_p-1:0] data_q [2];
  logic [1:0]          last_q;
  logic                wr_ptr, rd_ptr;
  logic [1:0]          occ, occ_nxt;
  logic [awidth_p-1:0] beat_cnt, cnt_base;
  logic                push, pop, head_last, room, grant, at_max;

  assign push           = s_valid_i & s_ready_o;
  assign pop            = fifo_wr_en_o;
  assign occ_nxt        = occ + {1'b0, push} - {1'b0, pop};
  assign head_last      = last_q[rd_ptr];
  assign room           = 32'(fifo_wr_space_avail_i) >= maxpkt_p;
  assign grant          = ~pktmode_p | (state != IDLE) | room;
  assign fifo_wr_en_o   = (occ != 2'd0) & ~fifo_wr_full_i & grant;
  assign fifo_wr_data_o = data_q[rd_ptr];
  assign busy_o         = (state != IDLE) | (occ != 2'd0);
  // the beat being written is number cnt_base+1 of its packet
  assign cnt_base       = (state == IDLE) ? '0 : beat_cnt;
  assign at_max         = 32'(cnt_base) + 32'd1 >= maxpkt_p;

  always_ff @(posedge src_clk_i or negedge src_rst_an_i)
    if (!src_rst_an_i) begin
      data_q    <= '{default: '0};
      last_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= '0;
      s_ready_o <= 1'b1;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= s_data_i;
        last_q[wr_ptr] <= s_last_i;
        wr_ptr         <= ~wr_ptr;
      end
      rd_ptr    <= rd_ptr ^ pop;
      occ       <= occ_nxt;
      s_ready_o <= occ_nxt < 2'd2;
    end

  always_ff @(posedge src_clk_i or negedge src_rst_an_i)
    if (!src_rst_an_i) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      err_pktlen_o <= 1'b0;
    end else begin
      err_pktlen_o <= 1'b0;
      if (pktmode_p && pop) begin
        if (head_last) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else if (state != OVER) begin
          if (at_max) begin
            state        <= OVER;
            err_pktlen_o <= 1'b1;
            beat_cnt     <= awidth_p'(maxpkt_p);
          end else begin
            state    <= BURST;
            beat_cnt <= cnt_base + awidth_p'(1);
          end
        end
      end
    end
endmodule

// File: tb/tb_ucdp_afifo_wr.sv
// tb_ucdp_afifo_wr: vector, directed and randomized checks of packet- and stream-mode write adapters
module tb_ucdp_afifo_wr;
  logic       clk = 1'b0, rst_an = 1'b0;
  logic       valid = 1'b0, last = 1'b0, full = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] space = '0;
  logic       p_rdy, p_en, p_busy, p_err, s_rdy, s_en, s_busy, s_err;
  logic [7:0] p_data, s_data;
  int         ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  ucdp_afifo_wr u_pkt (
    .src_clk_i(clk), .src_rst_an_i(rst_an), .s_valid_i(valid), .s_ready_o(p_rdy),
    .s_data_i(data), .s_last_i(last), .fifo_wr_en_o(p_en), .fifo_wr_data_o(p_data),
    .fifo_wr_full_i(full), .fifo_wr_space_avail_i(space), .busy_o(p_busy), .err_pktlen_o(p_err)
  );

  ucdp_afifo_wr #(.pktmode_p(1'b0)) u_str (
    .src_clk_i(clk), .src_rst_an_i(rst_an), .s_valid_i(valid), .s_ready_o(s_rdy),
    .s_data_i(data), .s_last_i(last), .fifo_wr_en_o(s_en), .fifo_wr_data_o(s_data),
    .fifo_wr_full_i(full), .fifo_wr_space_avail_i(space), .busy_o(s_busy), .err_pktlen_o(s_err)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       f;
    logic [3:0] sp;
    logic       en;
    logic       rdy;
    logic       busy;
    logic       err;
    logic [7:0] wd;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic f,
                     input logic [3:0] sp, input logic en, input logic rdy, input logic busy,
                     input logic err, input logic [7:0] wd);
    vec_t x;
    x = '{v: v, d: d, l: l, f: f, sp: sp, en: en, rdy: rdy, busy: busy, err: err, wd: wd};
    tv.push_back(x);
  endtask

  task automatic do_reset();
    rst_an = 1'b0;
    valid  = 1'b0;
    last   = 1'b0;
    full   = 1'b0;
    data   = '0;
    space  = '0;
    repeat (2) @(posedge clk);
    #1 rst_an = 1'b1;
  endtask

  initial begin
    logic [8:0] qp[$], qs[$];
    logic [8:0] h;
    bit         inp, errn, ep, es, pushp, pushs;
    int         cnt, fcnt, wcnt, k;

    // reset values
    do_reset();
    chk("rst_p_rdy", p_rdy, 1);
    chk("rst_p_en", p_en, 0);
    chk("rst_p_data", p_data, 0);
    chk("rst_p_busy", p_busy, 0);
    chk("rst_p_err", p_err, 0);
    chk("rst_s_rdy", s_rdy, 1);
    chk("rst_s_busy", s_busy, 0);

    // reservation hold-off, single-beat, oversize, full during OVER
    add(1, 8'hA1, 0, 0, 3, 0, 1, 0, 0, 0);
    add(1, 8'hA2, 0, 0, 3, 0, 1, 1, 0, 0);
    add(1, 8'hA3, 1, 0, 3, 0, 0, 1, 0, 0);
    add(1, 8'hA3, 1, 0, 3, 0, 0, 1, 0, 0);
    add(1, 8'hA3, 1, 0, 4, 1, 0, 1, 0, 8'hA1);
    add(1, 8'hA3, 1, 0, 4, 1, 1, 1, 0, 8'hA2);
    add(0, 8'h00, 0, 0, 4, 1, 1, 1, 0, 8'hA3);
    add(0, 8'h00, 0, 0, 4, 0, 1, 0, 0, 0);
    add(1, 8'hB1, 1, 0, 4, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 4, 1, 1, 1, 0, 8'hB1);
    add(0, 8'h00, 0, 0, 4, 0, 1, 0, 0, 0);
    add(1, 8'hC1, 0, 0, 8, 0, 1, 0, 0, 0);
    add(1, 8'hC2, 0, 0, 8, 1, 1, 1, 0, 8'hC1);
    add(1, 8'hC3, 0, 0, 8, 1, 1, 1, 0, 8'hC2);
    add(1, 8'hC4, 0, 0, 8, 1, 1, 1, 0, 8'hC3);
    add(1, 8'hC5, 0, 0, 8, 1, 1, 1, 0, 8'hC4);
    add(1, 8'hC6, 1, 0, 8, 1, 1, 1, 1, 8'hC5);
    add(0, 8'h00, 0, 0, 8, 1, 1, 1, 0, 8'hC6);
    add(0, 8'h00, 0, 0, 8, 0, 1, 0, 0, 0);
    add(1, 8'hD1, 0, 0, 8, 0, 1, 0, 0, 0);
    add(1, 8'hD2, 0, 0, 8, 1, 1, 1, 0, 8'hD1);
    add(1, 8'hD3, 0, 0, 8, 1, 1, 1, 0, 8'hD2);
    add(1, 8'hD4, 0, 0, 8, 1, 1, 1, 0, 8'hD3);
    add(1, 8'hD5, 0, 0, 8, 1, 1, 1, 0, 8'hD4);
    add(1, 8'hD6, 1, 1, 8, 0, 1, 1, 1, 0);
    add(0, 8'h00, 0, 1, 8, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8, 1, 0, 1, 0, 8'hD5);
    add(0, 8'h00, 0, 0, 8, 1, 1, 1, 0, 8'hD6);
    add(0, 8'h00, 0, 0, 8, 0, 1, 0, 0, 0);
    foreach (tv[i]) begin
      valid = tv[i].v;
      data  = tv[i].d;
      last  = tv[i].l;
      full  = tv[i].f;
      space = tv[i].sp;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), p_en, tv[i].en);
      chk($sformatf("vec%0d_rdy", i), p_rdy, tv[i].rdy);
      chk($sformatf("vec%0d_busy", i), p_busy, tv[i].busy);
      chk($sformatf("vec%0d_err", i), p_err, tv[i].err);
      if (tv[i].en) chk($sformatf("vec%0d_data", i), p_data, tv[i].wd);
      @(posedge clk);
      #1;
    end

    // reset mid-burst, then the next packet must begin in IDLE
    do_reset();
    valid = 1'b1;
    space = 4'd8;
    data  = 8'hE1;
    @(posedge clk); #1 data = 8'hE2;
    @(posedge clk); #1 data = 8'hE3;
    @(posedge clk); #1 valid = 1'b0;
    chk("mid_en_pre", p_en, 1);
    #2 rst_an = 1'b0;
    #1;
    chk("mid_rdy", p_rdy, 1);
    chk("mid_en", p_en, 0);
    chk("mid_data", p_data, 0);
    chk("mid_busy", p_busy, 0);
    chk("mid_err", p_err, 0);
    @(posedge clk); #1 rst_an = 1'b1;
    valid = 1'b1;
    data  = 8'hF1;
    space = 4'd3;
    @(posedge clk); #1 valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_hold_en", p_en, 0);
      chk("post_hold_busy", p_busy, 1);
    end
    @(posedge clk); #1 space = 4'd8;
    @(negedge clk);
    chk("post_first_en", p_en, 1);
    chk("post_first_data", p_data, 8'hF1);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      data  = 8'(8'hF0 + i);
      last  = (i == 4);
      @(negedge clk);
      chk("post_err", p_err, 0);
    end
    @(posedge clk); #1 valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_err", p_err, 0);
    end
    chk("post_busy", p_busy, 0);

    // stream mode free run into a depth-8 FIFO with no reads
    do_reset();
    fcnt  = 0;
    wcnt  = 0;
    k     = 0;
    space = 4'd8;
    valid = 1'b1;
    data  = 8'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("str_nodrop", s_en & full, 0);
      if (s_en) chk("str_order", s_data, wcnt);
      @(posedge clk);
      if (valid && s_rdy) k++;
      if (s_en) begin
        wcnt++;
        fcnt++;
      end
      #1;
      full  = (fcnt == 8);
      space = 4'(8 - fcnt);
      valid = (k < 10);
      data  = 8'(k);
    end
    chk("str_writes", wcnt, 8);
    chk("str_accepted", k, 10);
    chk("str_rdy_low", s_rdy, 0);
    chk("str_busy", s_busy, 1);

    // randomized run against a beat-level reference model
    do_reset();
    inp  = 0;
    cnt  = 0;
    errn = 0;
    for (int c = 0; c < 3000; c++) begin
      valid = $urandom_range(0, 9) < 7;
      data  = 8'($urandom);
      last  = $urandom_range(0, 9) < 3;
      full  = $urandom_range(0, 6) == 0;
      space = 4'($urandom_range(0, 8));
      @(negedge clk);
      ep = qp.size() != 0 && !full && (inp || space >= 4);
      es = qs.size() != 0 && !full;
      chk("rnd_p_en", p_en, ep);
      chk("rnd_p_rdy", p_rdy, qp.size() < 2);
      chk("rnd_p_busy", p_busy, inp || qp.size() != 0);
      chk("rnd_p_err", p_err, errn);
      if (ep) begin
        h = qp[0];
        chk("rnd_p_data", p_data, h[7:0]);
      end
      chk("rnd_s_en", s_en, es);
      chk("rnd_s_rdy", s_rdy, qs.size() < 2);
      chk("rnd_s_busy", s_busy, qs.size() != 0);
      chk("rnd_s_err", s_err, 0);
      if (es) begin
        h = qs[0];
        chk("rnd_s_data", s_data, h[7:0]);
      end
      pushp = valid && qp.size() < 2;
      pushs = valid && qs.size() < 2;
      @(posedge clk);
      errn = 0;
      if (ep) begin
        h = qp.pop_front();
        if (!inp) begin
          if (!h[8]) begin
            inp = 1;
            cnt = 1;
          end
        end else begin
          cnt++;
          if (h[8]) begin
            inp = 0;
            cnt = 0;
          end else if (cnt == 4) errn = 1;
        end
      end
      if (es) void'(qs.pop_front());
      if (pushp) qp.push_back({last, data});
      if (pushs) qs.push_back({last, data});
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
